// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI responder shift engine.
//   - state_t   : link state (IDLE / ACTIVE)
//   - MODE0..3  : SPI mode constants encoded as {cpol, cpha}
//   - DATA_W_DEF: default frame width in bits
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin followed by
// a rise/fall pulse detector (synced level against a 1-cycle delayed copy).
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   rise     : one-cycle pulse, synced level went 0 -> 1
//   fall     : one-cycle pulse, synced level went 1 -> 0
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   level_p1;
    logic                   level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p   <= '0;
            level_p1 <= 1'b0;
        end else begin
            sync_p   <= {sync_p[SYNC_STAGES-2:0], din};
            level_p1 <= level;
        end
    end

    assign level = sync_p[SYNC_STAGES-1];
    assign rise  = level & ~level_p1;
    assign fall  = ~level & level_p1;

endmodule

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: SPI responder shift engine, all four CPOL/CPHA modes,
// MSB first, back-to-back frames while ss_n stays low. SCK, SS_n and MOSI are
// oversampled in the clk domain.
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   cpol, cpha     : SPI mode, captured only while IDLE
//   sck_in, ss_n, mosi : asynchronous pins from the master
//   miso, miso_oe  : serial data out (tx shift MSB) and its enable
//   tx_data/tx_valid/tx_ready : 1-entry tx holding buffer write port
//   rx_data/rx_valid : last complete received word, one-cycle update pulse
//   tx_underrun    : pulse, a frame was loaded with zeros (buffer empty)
//   frame_abort    : pulse, ss_n released mid-word
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sck_in,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t state, state_next;

    logic                   cpol_q, cpha_q;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_p;
    logic                   mosi_s;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift, tx_shift, buf_data;
    logic                   buf_full, load_pend;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic sel_evt, desel_evt, do_sample, do_shift, load, tx_wr, last_bit;

    // Input synchronisation and edge detection
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck_in),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_p <= '0;
        else     mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_p[SYNC_STAGES-1];

    // Edge classification: leading edge leaves the idle level, trailing returns to it
    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

    assign sel_evt   = (state == IDLE)   && ss_fall;
    assign desel_evt = (state == ACTIVE) && ss_rise;
    // A deselect in the same cycle as an SCK edge suppresses that edge.
    assign do_sample = (state == ACTIVE) && !ss_rise && sample_edge;
    assign do_shift  = (state == ACTIVE) && !ss_rise && shift_edge;
    // cpha is still being captured on the select cycle, so use the live pin there.
    assign load      = (sel_evt && !cpha) || (do_shift && load_pend);
    assign tx_wr     = tx_valid && !buf_full;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign tx_ready  = ~buf_full;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = ACTIVE;
            ACTIVE:  if (ss_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        miso    = 1'b0;
        miso_oe = 1'b0;
        if (state == ACTIVE) begin
            miso    = tx_shift[DATA_W-1];
            miso_oe = 1'b1;
        end
    end

    // Shift datapath, holding buffer and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            load_pend   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;

            if (state == IDLE) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
            end

            // No bypass: a write that coincides with a load serves the next frame.
            if (tx_wr) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end

            if (load) begin
                load_pend <= 1'b0;
                if (buf_full) begin
                    tx_shift <= buf_data;
                    buf_full <= 1'b0;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (do_shift) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (sel_evt) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                load_pend <= cpha;
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (last_bit) begin
                    bit_cnt   <= '0;
                    load_pend <= 1'b1;
                    rx_data   <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_valid  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            // Deselect drops the partial word and the loaded tx word; buffer kept.
            if (desel_evt) begin
                frame_abort <= (bit_cnt != '0);
                bit_cnt     <= '0;
                rx_shift    <= '0;
                tx_shift    <= '0;
                load_pend   <= 1'b0;
            end
        end
    end

endmodule
